// File: rtl/mem_read_ctrl_pkg.sv
// rtl/mem_read_ctrl_pkg.sv - shared widths and state encoding for the memory access controller
package mem_read_ctrl_pkg;

    // Default widths, shared with the register file and MDR
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;

    // Wait-state counter width; wait parameters must fit in 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_BUSY = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_read_ctrl_mar_reg.sv
// rtl/mem_read_ctrl_mar_reg.sv - memory address register, keeps the low address bits of the bus
module mem_read_ctrl_mar_reg
    import mem_read_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] mar_d;
    logic [ADDR_W-1:0] mar_q;

    // Upper bus bits are discarded by design
    logic unused_hi;
    assign unused_hi = ^d[DATA_W-1:ADDR_W];

    // Next MAR value: load the truncated bus when requested, otherwise hold
    always_comb begin
        mar_d = mar_q;
        if (load) begin
            mar_d = d[ADDR_W-1:0];
        end
    end

    // MAR storage with asynchronous clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mar_q <= '0;
        end else begin
            mar_q <= mar_d;
        end
    end

    assign q = mar_q;

endmodule

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - MAR owner and RAM read/write sequencer with fixed wait states
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MARin,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] MDRout_q,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    // The counter is 4 bits and never wraps, so wait counts outside 1..15 cannot be sequenced
    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("mem_read_ctrl: RD_WAIT must be within 1..15");
    end
    if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
        $error("mem_read_ctrl: WR_WAIT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    logic [ADDR_W-1:0] mar_q;

    state_t            state_d,   state_q;
    logic [CNT_W-1:0]  cnt_d,     cnt_q;
    logic [ADDR_W-1:0] addr_d,    addr_q;
    logic [DATA_W-1:0] mdatain_d, mdatain_q;
    logic [DATA_W-1:0] wdata_d,   wdata_q;
    logic              done_d,    done_q;
    logic              re_d,      re_q;
    logic              we_d,      we_q;

    mem_read_ctrl_mar_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mar (
        .clk  (clk),
        .clr  (clr),
        .load (MARin),
        .d    (BusMuxOut),
        .q    (mar_q)
    );

    // Next-state logic: accept a request in IDLE (read wins), count wait states, pulse done
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mdatain_d = mdatain_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        done_d    = 1'b0;
        re_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The address copy is taken here so later MAR loads cannot disturb an access
                if (mem_rd) begin
                    addr_d  = mar_q;
                    re_d    = 1'b1;
                    cnt_d   = RD_LOAD;
                    state_d = S_RD_WAIT;
                end else if (mem_wr) begin
                    addr_d  = mar_q;
                    wdata_d = MDRout_q;
                    we_d    = 1'b1;
                    cnt_d   = WR_LOAD;
                    state_d = S_WR_BUSY;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mdatain_d = ram_rdata;
                    state_d   = S_DONE;
                end
            end
            S_WR_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; clear aborts any access in flight
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            mdatain_q <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            mdatain_q <= mdatain_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            re_q      <= re_d;
            we_q      <= we_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign Mdatain   = mdatain_q;
    assign mem_done  = done_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_re    = re_q;
    assign ram_we    = we_q;

endmodule

// File: doc/mem_read_ctrl.md
Name: mem_read_ctrl

Overview:
- Memory access controller between the control unit and the main RAM.
- Directly upstream of the MDR input mux: it owns the MAR and sequences RAM reads and writes with a fixed number of wait states.
- Returns read data on Mdatain with a one-cycle done strobe, so control asserts Read and MDRin only after data is valid.
- Also drives write data from the MDR to RAM.

Parameters:
- DATA_W, 32, data word width (bus, MDR, RAM data).
- ADDR_W, 9, RAM address width; MAR holds the low ADDR_W bits of the bus.
- RD_WAIT, 2, RAM read latency in cycles, from ram_re pulse to valid ram_rdata; legal range 1..15.
- WR_WAIT, 1, cycles ram_we is held high per write; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- MARin  in  1  load MAR from BusMuxOut at the clock edge.
- BusMuxOut  in  DATA_W  internal CPU bus.
- mem_rd  in  1  read request; sampled only in IDLE.
- mem_wr  in  1  write request; sampled only in IDLE.
- MDRout_q  in  DATA_W  current MDR contents (write data).
- Mdatain  out  DATA_W  registered read data presented to the MDR input mux.
- mem_done  out  1  one-cycle pulse when a read or write completes.
- busy  out  1  high whenever state is not IDLE.
- ram_addr  out  ADDR_W  RAM address, driven from MAR.
- ram_wdata  out  DATA_W  RAM write data.
- ram_re  out  1  RAM read enable, one-cycle pulse.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (clr high, asynchronous): state=IDLE, MAR=0, Mdatain=0, ram_wdata=0, counter=0, mem_done=0, busy=0, ram_re=0, ram_we=0.
- Reset mid-access aborts the access immediately; no done pulse is produced.
- MAR: on a rising edge with MARin=1, MAR <= BusMuxOut[ADDR_W-1:0]. Upper bits are discarded.
  - MARin is honoured in every state, but ram_addr is driven from a copy latched at request acceptance, so the address stays stable for the whole access.
- State IDLE:
  - mem_rd=1: latch address, pulse ram_re for one cycle, counter <= RD_WAIT-1, go to RD_WAIT.
  - else mem_wr=1: latch address, ram_wdata <= MDRout_q, ram_we=1, counter <= WR_WAIT-1, go to WR_BUSY.
  - mem_rd and mem_wr both high: read wins; the write is dropped, not queued.
- State RD_WAIT:
  - While counter != 0, decrement.
  - When counter == 0: Mdatain <= ram_rdata, go to DONE.
  - Read data is therefore captured RD_WAIT cycles after the ram_re edge.
- State WR_BUSY:
  - ram_we stays high.
  - Decrement counter; at 0, drop ram_we and go to DONE.
- State DONE:
  - mem_done=1 for exactly one cycle, then go to IDLE.
  - Requests are ignored in DONE.
- Mdatain holds its value until the next read completes; writes never change it.
- Requests arriving while busy=1 are ignored; control must hold mem_rd/mem_wr until it sees mem_done.
  - A request still high in the IDLE cycle after DONE starts a new access (back-to-back allowed).
- Total read latency, request edge to mem_done high: RD_WAIT+1 cycles. Write: WR_WAIT+1 cycles.
- Counter width: 4 bits, with no wrap. Values outside 1..15 are illegal; flag them with an elaboration-time check.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE=2'd0, RD_WAIT=2'd1, WR_BUSY=2'd2, DONE=2'd3;
  - DATA_W and ADDR_W defaults, shared with the register file and MDR.
- One sub-module is natural: mar_reg, a DATA_W-in/ADDR_W-out load-enable register with async clear.
- State machine, counter and data capture stay in the top level.

Test Plan:
- Reset: assert clr mid-read (state RD_WAIT) -> next sample shows busy=0, ram_re=0, Mdatain=0, MAR=0, and no mem_done pulse ever follows.
- Basic read: MARin with BusMuxOut=32'h00000010; RAM model holds 32'hDEADBEEF at 0x10 with RD_WAIT=2; pulse mem_rd -> ram_addr=0x010, ram_re high one cycle, mem_done 3 cycles after request, Mdatain=32'hDEADBEEF.
- Write: MDRout_q=32'h00000001, MAR=0x20, mem_wr -> ram_we high for WR_WAIT cycles with ram_wdata=1, mem_done at +2; a subsequent read of 0x20 returns 32'h00000001.
- Simultaneous mem_rd=mem_wr=1 at address 0x05 -> only ram_re pulses, ram_we stays 0, RAM contents unchanged.
- Busy rejection plus back-to-back: during a read, toggle mem_wr and change MARin/BusMuxOut -> ram_addr stays constant and no write occurs; holding mem_rd high through DONE starts a second read in the next cycle.
- Address truncation: BusMuxOut=32'hFFFF_FE03 with ADDR_W=9 -> ram_addr=9'h003.
